serial_subtractor: RTL
======================

Name: serial_subtractor

Overview:
- Bit-serial two's-complement subtractor: computes a - b one bit per clock, LSB first, with a single borrow flip-flop.
- Subtraction counterpart to the team's combinational half adder; reuses the half-adder XOR/AND cell idea with the borrow form.
- Sits beside the Hack ALU as an area-cheap arithmetic unit. Valid/ready handshakes on both the operand side and the result side.

Parameters:
WIDTH, 16, operand and result width in bits (>= 2)

Ports:
clk  input  1  rising-edge clock, single clock domain
rst_n  input  1  synchronous reset, active-low
start_valid  input  1  operands a/b are valid
start_ready  output  1  block can accept operands
a  input  WIDTH  minuend, sampled only on the start handshake
b  input  WIDTH  subtrahend, sampled only on the start handshake
busy  output  1  high while a subtraction is in progress
done_valid  output  1  result registers hold a new result
done_ready  input  1  consumer accepts the result
diff  output  WIDTH  a - b modulo 2^WIDTH
borrow  output  1  1 iff unsigned a < b
zr  output  1  diff == 0
ng  output  1  diff[WIDTH-1]

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is synchronous and active-low, sampled on the rising edge of clk.
- Reset state: state=IDLE, busy=0, done_valid=0, diff=0, borrow=0, zr=0, ng=0.
- start_ready is 1 only when state==IDLE and rst_n==1. It is combinationally masked low while rst_n is low.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start_ready=1.
  - On the edge where start_valid && start_ready: load a into shift register sa and b into shift register sb, clear the borrow FF, clear the bit counter, go to SHIFT.
  - a and b are ignored in all other cycles.
- SHIFT:
  - busy=1. Each edge: d = sa[0]^sb[0]^bw and bw' = (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&bw).
  - d shifts into the MSB of result shift register sr; sa and sb shift right; counter increments.
  - On the edge that processes bit WIDTH-1: copy the final sr into diff, final bw' into borrow, and set zr and ng from that same final value. Go to DONE.
- Latency: start handshake at edge N, so done_valid=1 in the cycle following edge N+WIDTH (exactly WIDTH SHIFT cycles).
- DONE:
  - done_valid=1, busy=0, start_ready=0.
  - On the edge with done_ready=1: go to IDLE and clear done_valid.
  - While done_ready=0: stay in DONE; done_valid, diff and flags hold stable.
- diff/borrow/zr/ng are updated only on the SHIFT→DONE transition. They hold their value through IDLE until the next result.
- done_ready is ignored outside DONE. start_valid is ignored outside IDLE, so no back-to-back overlap.
- Reset mid-operation (rst_n low in SHIFT or DONE): the next edge gives the full reset state. Partial results are discarded and no done_valid pulse is produced.
- Arithmetic wraps modulo 2^WIDTH. No overflow flag; signed overflow is not reported.

Test Plan:
- rst_n low for 2 cycles with start_valid=1 -> start_ready=0 during reset, all outputs 0, no capture; start_ready=1 in the first cycle after release.
- a=5, b=3, handshake at edge N -> done_valid rises after edge N+16; diff=0x0002, borrow=0, zr=0, ng=0.
- a=3, b=5 -> diff=0xFFFE, borrow=1, ng=1, zr=0; then a=0x0000, b=0xFFFF -> diff=0x0001, borrow=1.
- a=0x8000, b=0x8000 -> diff=0x0000, zr=1, borrow=0, ng=0.
- Hold done_ready=0 for 5 cycles with start_valid=1 and new operands -> done_valid, diff and flags stable, start_ready=0; after done_ready=1 -> IDLE next cycle, new operands accepted, prior diff held until the new result.
- Assert rst_n=0 after 7 SHIFT cycles -> next cycle IDLE, busy=0, done_valid=0, diff=0; no done_valid in the following 20 cycles without a new start.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: computes a - b LSB first, one bit per
// clock, with a single borrow flip-flop and valid/ready handshakes on both sides.
module serial_subtractor #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done_valid,
   input  logic             done_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             zr,
   output logic             ng
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic [WIDTH-1:0] sr;
   logic             bw;
   logic [CW-1:0]    cnt;

   logic             d;
   logic             bw_next;
   logic [WIDTH-1:0] sr_next;

   // Full-subtractor cell built from the half-adder XOR/AND pair in borrow form.
   always_comb begin
      d       = sa[0] ^ sb[0] ^ bw;
      bw_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & bw);
      sr_next = {d, sr[WIDTH-1:1]};
   end

   assign start_ready = rst_n && (state == IDLE);
   assign busy        = (state == SHIFT);
   assign done_valid  = (state == DONE);

   // Result outputs change only when the last bit is processed, so they stay
   // stable through DONE and IDLE until the next subtraction completes.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         sa     <= '0;
         sb     <= '0;
         sr     <= '0;
         bw     <= 1'b0;
         cnt    <= '0;
         diff   <= '0;
         borrow <= 1'b0;
         zr     <= 1'b0;
         ng     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start_valid) begin
                  sa    <= a;
                  sb    <= b;
                  bw    <= 1'b0;
                  cnt   <= '0;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               sa  <= sa >> 1;
               sb  <= sb >> 1;
               sr  <= sr_next;
               bw  <= bw_next;
               cnt <= cnt + CW'(1);
               if (cnt == LAST) begin
                  diff   <= sr_next;
                  borrow <= bw_next;
                  zr     <= (sr_next == '0);
                  ng     <= sr_next[WIDTH-1];
                  state  <= DONE;
               end
            end
            DONE: begin
               if (done_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
